fir_coeff_loader: RTL and testbench
===================================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter TAPS, default 15, number of filter coefficients.
REQ-002 SHALL have parameter TAPS_WIDTH, default 16, coefficient width (signed).
REQ-003 SHALL have parameter TAPS_ADDR_WIDTH, default $clog2(TAPS+1), coefficient address width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_we_i  input  1  host write strobe into the shadow bank.
REQ-007 SHALL have port cfg_addr_i  input  TAPS_ADDR_WIDTH  host shadow-bank address.
REQ-008 SHALL have port cfg_data_i  input  TAPS_WIDTH  host coefficient value.
REQ-009 SHALL have port start_i  input  1  one-cycle request to begin a load/verify sequence.
REQ-010 SHALL have port rd_only_i  input  1  sampled with start_i; 1 = skip the write phase.
REQ-011 SHALL have port coeff_o  output  1  filter coefficient-port write enable (1 = write, 0 = read).
REQ-012 SHALL have port coeff_addr_o  output  TAPS_ADDR_WIDTH  filter coefficient address.
REQ-013 SHALL have port coeff_data_io  inout  TAPS_WIDTH  shared coefficient bus; driven only while coeff_o=1, else high-Z.
REQ-014 SHALL have port busy_o  output  1  sequence in progress.
REQ-015 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-016 SHALL have port err_o  output  1  readback mismatch seen in last sequence.
REQ-017 SHALL have port err_cnt_o  output  TAPS_ADDR_WIDTH  mismatch count of last sequence.
REQ-018 SHALL have port first_err_addr_o  output  TAPS_ADDR_WIDTH  lowest mismatching address of last sequence.

Function
REQ-019 SHALL hold a TAPS-entry signed shadow bank; cfg_we_i writes bank[cfg_addr_i] at the clock edge when busy_o=0 and cfg_addr_i<TAPS; all other writes ignored.
REQ-020 SHALL implement FSM states IDLE, WRITE, TURN, READ, DRAIN, DONE.
REQ-021 SHALL, in IDLE, accept start_i=1 and go to WRITE (rd_only_i=0) or READ (rd_only_i=1), clearing err_o, err_cnt_o, first_err_addr_o; start_i outside IDLE is ignored.
REQ-022 SHALL, in WRITE, present coeff_o=1, coeff_addr_o=k, coeff_data_io=bank[k] for k=0..TAPS-1, one address per cycle, then go to TURN.
REQ-023 SHALL spend exactly one cycle in TURN with coeff_o=0 and the bus released, then go to READ.
REQ-024 SHALL, in READ, present coeff_o=0, coeff_addr_o=k for k=0..TAPS-1, one per cycle, then go to DRAIN for exactly 2 cycles.
REQ-025 SHALL sample coeff_data_io for address k on the second rising edge after the cycle in which coeff_addr_o=k is presented, and compare it with bank[k].
REQ-026 SHALL, per mismatch, set err_o, increment err_cnt_o (saturating at all-ones), and record first_err_addr_o on the first mismatch only.
REQ-027 SHALL spend one cycle in DONE with done_o=1, then return to IDLE.
REQ-028 SHALL assert done_o exactly 2*TAPS+4 cycles after the start-accept edge (rd_only_i=0) and TAPS+3 cycles after it (rd_only_i=1).
REQ-029 SHALL drive busy_o=1 in every state except IDLE; all outputs registered.
REQ-030 SHALL hold err_o, err_cnt_o, first_err_addr_o stable from DONE until the next accepted start.

Reset
REQ-031 SHALL, with rst_ni=0, immediately force IDLE, coeff_o=0, bus high-Z, coeff_addr_o=0, busy_o=0, done_o=0, err_o=0, err_cnt_o=0, first_err_addr_o=0, shadow bank all zero.
REQ-032 SHALL abort any in-progress sequence on reset without emitting done_o.

Structure
REQ-033 SHALL place FSM state encoding and default TAPS/TAPS_WIDTH constants in shared package fir_pkg.
REQ-034 SHALL be a single module with no sub-modules; bus tri-state uses one conditional assign keyed on registered coeff_o.

Verification
REQ-035 SHALL cover: program bank 0..14 = 1..15, start rd_only=0 against filter -> filter taps = 1..15, done at +34 cycles, err_o=0, err_cnt_o=0.
REQ-036 SHALL cover: after REQ-035, force filter tap 7 = 0, start rd_only=1 -> done at +18 cycles, err_o=1, err_cnt_o=1, first_err_addr_o=7.
REQ-037 SHALL cover: start_i pulsed during WRITE and cfg_we_i during READ -> both ignored, bank and sequence unchanged.
REQ-038 SHALL cover: rst_ni low during READ cycle 5 -> coeff_o=0, busy_o=0 immediately, no done_o, bank zero.
REQ-039 SHALL cover: cfg_addr_i=15 write of 0x7FFF -> ignored, bank[14] unchanged; no bus contention (X) on coeff_data_io at any cycle.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR coefficient loader.
package fir_pkg;

  localparam int FIR_TAPS       = 15;
  localparam int FIR_TAPS_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_TURN,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } fir_state_e;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Host-side control/status bundle of the FIR coefficient loader.
interface fir_coeff_loader_if
  import fir_pkg::*;
#(
  parameter int AW = $clog2(FIR_TAPS + 1),
  parameter int DW = FIR_TAPS_WIDTH
);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          start;
  logic          rd_only;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, rd_only,
    input  busy, done, err, err_cnt, first_err_addr
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, rd_only,
    output busy, done, err, err_cnt, first_err_addr
  );

endinterface

// File: rtl/fir_coeff_loader.sv
// Loads a shadow coefficient bank into a FIR filter over a shared tri-state
// bus, then reads every tap back and reports mismatches.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int TAPS            = FIR_TAPS,
  parameter int TAPS_WIDTH      = FIR_TAPS_WIDTH,
  parameter int TAPS_ADDR_WIDTH = $clog2(TAPS + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_we_i,
  input  logic [TAPS_ADDR_WIDTH-1:0] cfg_addr_i,
  input  logic [TAPS_WIDTH-1:0]      cfg_data_i,
  input  logic                       start_i,
  input  logic                       rd_only_i,
  output logic                       coeff_o,
  output logic [TAPS_ADDR_WIDTH-1:0] coeff_addr_o,
  inout  wire  [TAPS_WIDTH-1:0]      coeff_data_io,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [TAPS_ADDR_WIDTH-1:0] err_cnt_o,
  output logic [TAPS_ADDR_WIDTH-1:0] first_err_addr_o
);

  localparam logic [TAPS_ADDR_WIDTH-1:0] LAST_ADDR = TAPS_ADDR_WIDTH'(TAPS - 1);
  localparam logic [TAPS_ADDR_WIDTH-1:0] ADDR_ONE  = TAPS_ADDR_WIDTH'(1);

  fir_state_e                   state_q;
  logic signed [TAPS_WIDTH-1:0] bank_q [TAPS];
  logic [TAPS_WIDTH-1:0]        wr_data_q;
  logic                         drain_q;
  logic                         rd_vld_q;
  logic [TAPS_ADDR_WIDTH-1:0]   rd_addr_q;

  // The bus is released whenever the registered write enable is low.
  assign coeff_data_io = coeff_o ? wr_data_q : 'z;

  // NOTE: every register here is assigned with <= so that all of them update
  // together from pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      // NOTE: the bank is reset explicitly because a zeroed bank is part of
      // the reset state; this forces it into flops rather than a RAM macro.
      bank_q           <= '{default: '0};
      wr_data_q        <= '0;
      drain_q          <= 1'b0;
      rd_vld_q         <= 1'b0;
      rd_addr_q        <= '0;
      coeff_o          <= 1'b0;
      coeff_addr_o     <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      done_o    <= 1'b0;
      rd_vld_q  <= (state_q == ST_READ);
      rd_addr_q <= coeff_addr_o;

      if (cfg_we_i && !busy_o && (cfg_addr_i <= LAST_ADDR)) begin
        bank_q[cfg_addr_i] <= cfg_data_i;
      end

      // Readback for an address lands two edges after it was presented.
      if (rd_vld_q && (coeff_data_io != bank_q[rd_addr_q])) begin
        err_o <= 1'b1;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ADDR_ONE;
        if (!err_o) first_err_addr_o <= rd_addr_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_o           <= 1'b1;
            err_o            <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            coeff_addr_o     <= '0;
            if (rd_only_i) begin
              state_q <= ST_READ;
            end else begin
              state_q   <= ST_WRITE;
              coeff_o   <= 1'b1;
              wr_data_q <= bank_q[0];
            end
          end
        end
        ST_WRITE: begin
          if (coeff_addr_o == LAST_ADDR) begin
            state_q      <= ST_TURN;
            coeff_o      <= 1'b0;
            coeff_addr_o <= '0;
          end else begin
            coeff_addr_o <= coeff_addr_o + ADDR_ONE;
            wr_data_q    <= bank_q[coeff_addr_o + ADDR_ONE];
          end
        end
        ST_TURN: begin
          state_q      <= ST_READ;
          coeff_addr_o <= '0;
        end
        ST_READ: begin
          if (coeff_addr_o == LAST_ADDR) begin
            state_q <= ST_DRAIN;
            drain_q <= 1'b0;
          end else begin
            coeff_addr_o <= coeff_addr_o + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          if (drain_q) begin
            state_q <= ST_DONE;
            done_o  <= 1'b1;
            drain_q <= 1'b0;
          end else begin
            drain_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a behavioural filter coefficient port.
module tb_fir_coeff_loader;
  import fir_pkg::*;

  localparam int AW = $clog2(FIR_TAPS + 1);
  localparam int DW = FIR_TAPS_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_coeff_loader_if #(.AW(AW), .DW(DW)) cif ();

  logic          coeff_o;
  logic [AW-1:0] coeff_addr;
  wire  [DW-1:0] coeff_bus;

  fir_coeff_loader dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cfg_we_i         (cif.cfg_we),
    .cfg_addr_i       (cif.cfg_addr),
    .cfg_data_i       (cif.cfg_data),
    .start_i          (cif.start),
    .rd_only_i        (cif.rd_only),
    .coeff_o          (coeff_o),
    .coeff_addr_o     (coeff_addr),
    .coeff_data_io    (coeff_bus),
    .busy_o           (cif.busy),
    .done_o           (cif.done),
    .err_o            (cif.err),
    .err_cnt_o        (cif.err_cnt),
    .first_err_addr_o (cif.first_err_addr)
  );

  // Filter tap memory: writes on the edge, reads return data one edge after the address.
  logic [DW-1:0] filt [FIR_TAPS];
  logic          flt_oe_q = 1'b0;
  logic [AW-1:0] flt_addr_q = '0;
  logic          poke;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;

  always @(posedge clk) begin
    if (coeff_o) filt[coeff_addr] <= coeff_bus;
    else if (poke) filt[poke_addr] <= poke_data;
    flt_oe_q   <= !coeff_o;
    flt_addr_q <= coeff_addr;
  end

  assign coeff_bus = (flt_oe_q && !coeff_o) ? filt[flt_addr_q] : 'z;

  int x_cnt    = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (coeff_o && $isunknown(coeff_bus)) x_cnt <= x_cnt + 1;
    if (cif.done) done_cnt <= done_cnt + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    cif.cfg_we   = 1'b1;
    cif.cfg_addr = AW'(addr);
    cif.cfg_data = DW'(data);
    @(negedge clk);
    cif.cfg_we   = 1'b0;
  endtask

  // n counts rising edges starting with the accept edge as 1, up to the one
  // that raises done_o; inputs injected "at n" are sampled on edge n+1.
  task automatic run_seq(input logic rd_only, input int inj_start, input int inj_we,
                         input int rst_at, output int n);
    n = 0;
    cif.start   = 1'b1;
    cif.rd_only = rd_only;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    while (n < 100) begin
      if (n == 5) check("busy_mid", 32'(cif.busy), 1);
      if (!rd_only && n == 1) begin
        check("wr_coeff_o", 32'(coeff_o), 1);
        check("wr_addr0", 32'(coeff_addr), 0);
        check("wr_bus0", 32'(coeff_bus), 1);
      end
      if (!rd_only && n == 16) check("turn_coeff_o", 32'(coeff_o), 0);
      if (!rd_only && n == 20) begin
        check("rd_addr3", 32'(coeff_addr), 3);
        check("rd_coeff_o", 32'(coeff_o), 0);
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_async_coeff_o", 32'(coeff_o), 0);
        check("rst_async_busy", 32'(cif.busy), 0);
        check("rst_async_addr", 32'(coeff_addr), 0);
        break;
      end
      if (cif.done) break;
      cif.start    = (n == inj_start);
      cif.cfg_we   = (n == inj_we);
      cif.cfg_addr = AW'(3);
      cif.cfg_data = 16'h1234;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    cif.start  = 1'b0;
    cif.cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    int d0;
    rst_n        = 1'b0;
    cif.cfg_we   = 1'b0;
    cif.cfg_addr = '0;
    cif.cfg_data = '0;
    cif.start    = 1'b0;
    cif.rd_only  = 1'b0;
    poke         = 1'b0;
    poke_addr    = '0;
    poke_data    = '0;

    repeat (3) @(negedge clk);
    check("rst_coeff_o", 32'(coeff_o), 0);
    check("rst_addr", 32'(coeff_addr), 0);
    check("rst_busy", 32'(cif.busy), 0);
    check("rst_done", 32'(cif.done), 0);
    check("rst_err", 32'(cif.err), 0);
    check("rst_err_cnt", 32'(cif.err_cnt), 0);
    check("rst_first_err", 32'(cif.first_err_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bank = 1..15, then an out-of-range write that must not land anywhere.
    for (int k = 0; k < FIR_TAPS; k++) cfg_write(k, k + 1);
    cfg_write(15, 16'h7FFF);

    // Full load + verify; a stray start in WRITE and a cfg write in READ are ignored.
    run_seq(1'b0, 3, 17, 0, n);
    check("s1_done_cycles", n, 2 * FIR_TAPS + 4);
    check("s1_err", 32'(cif.err), 0);
    check("s1_err_cnt", 32'(cif.err_cnt), 0);
    check("s1_first_err", 32'(cif.first_err_addr), 0);
    @(negedge clk);
    check("s1_done_pulse", 32'(cif.done), 0);
    check("s1_busy_end", 32'(cif.busy), 0);
    for (int k = 0; k < FIR_TAPS; k++)
      check($sformatf("s1_filt_%0d", k), 32'(filt[AW'(k)]), k + 1);

    // Corrupt tap 7 in the filter, then verify only.
    poke      = 1'b1;
    poke_addr = AW'(7);
    poke_data = '0;
    @(negedge clk);
    poke = 1'b0;
    run_seq(1'b1, 0, 0, 0, n);
    check("s2_done_cycles", n, FIR_TAPS + 3);
    check("s2_err", 32'(cif.err), 1);
    check("s2_err_cnt", 32'(cif.err_cnt), 1);
    check("s2_first_err", 32'(cif.first_err_addr), 7);
    repeat (3) @(negedge clk);
    check("s2_err_hold", 32'(cif.err_cnt), 1);

    // Reset during READ cycle 5: abort silently and zero the bank.
    d0 = done_cnt;
    run_seq(1'b1, 0, 0, 5, n);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("s3_no_done", done_cnt, d0);
    check("s3_busy", 32'(cif.busy), 0);
    check("s3_err_cleared", 32'(cif.err), 0);

    // Zero bank against filter 1..15 with tap 7 = 0: every other tap mismatches.
    run_seq(1'b1, 0, 0, 0, n);
    check("s4_done_cycles", n, FIR_TAPS + 3);
    check("s4_err", 32'(cif.err), 1);
    check("s4_err_cnt", 32'(cif.err_cnt), 14);
    check("s4_first_err", 32'(cif.first_err_addr), 0);
    @(negedge clk);

    check("bus_unknown_cycles", x_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
